burst_mem_responder: RTL and testbench



---
 rtl/burst_mem_pkg.sv | 19 +
 rtl/burst_mem_array.sv | 27 ++
 rtl/burst_mem_responder.sv | 148 ++++++++++++++
 tb/tb_burst_mem_responder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/burst_mem_pkg.sv
// Shared constants and types for the burst memory responder.
// Optional feature macro used by the top: BURSTMEM_CRITICAL_WORD_FIRST_EN.
package burst_mem_pkg;

  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;
  localparam int BEATS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } state_e;

  typedef logic [1:0] beat_idx_t;

endpackage

// File: rtl/burst_mem_array.sv
// Line store: 2**IDX_BITS lines of LINE_W bits, one combinational read
// port and one synchronous write port. Contents are never reset.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] ridx_i,
  output logic [LINE_W-1:0]   rdata_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] widx_i,
  input  logic [LINE_W-1:0]   wdata_i
);

  logic [LINE_W-1:0] mem_q [2**IDX_BITS];

  // Commit a full line on a write strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat, 64-bit burst protocol.
// One 256-bit line request is accepted in IDLE; after LATENCY wait cycles
// four beats are streamed (read) or absorbed (write) with resp_o high.
// Optional macro BURSTMEM_CRITICAL_WORD_FIRST_EN: read beats start at the
// addressed 64-bit word (address_i[4:3]) and wrap.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int LATENCY  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
);

  localparam logic [3:0] LAST_WAIT = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  beat_idx_t           beat_q, beat_d;
  beat_idx_t           start_q, start_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                is_rd_q, is_rd_d;
  logic [LINE_W-1:0]   buf_q;

  logic [LINE_W-1:0]   rdata;
  logic                we;
  logic [LINE_W-1:0]   wdata;
  logic                last_wait;
  beat_idx_t           rd_beat;
  beat_idx_t           req_start;
  logic                unused_addr;

  // Only the index (and the critical word, when enabled) matter.
  assign unused_addr = ^address_i;

`ifdef BURSTMEM_CRITICAL_WORD_FIRST_EN
  assign req_start = address_i[4:3];
`else
  assign req_start = 2'd0;
`endif

  assign last_wait = (cnt_q == LAST_WAIT);

  // The final beat is merged straight from burst_i so the whole line lands
  // on the edge that ends beat 3; a reset in that cycle drops the write.
  assign we    = reset_n && (state_q == WBURST) && (beat_q == 2'd3);
  assign wdata = {burst_i, buf_q[3*BEAT_W-1:0]};

  burst_mem_array #(
    .IDX_BITS (IDX_BITS)
  ) u_array (
    .clk     (clk),
    .ridx_i  (idx_q),
    .rdata_o (rdata),
    .we_i    (we),
    .widx_i  (idx_q),
    .wdata_i (wdata)
  );

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      start_q <= '0;
      idx_q   <= '0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      is_rd_q <= is_rd_d;
    end
  end

  // Line buffer: loaded from the store at the end of a read wait, filled
  // beat by beat during a write burst.
  always_ff @(posedge clk) begin
    if (state_q == WAIT && is_rd_q && last_wait) begin
      buf_q <= rdata;
    end else if (state_q == WBURST) begin
      buf_q[BEAT_W*beat_q +: BEAT_W] <= burst_i;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, read wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    start_d = start_q;
    idx_d   = idx_q;
    is_rd_d = is_rd_q;
    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = WAIT;
          is_rd_d = 1'b1;
          idx_d   = address_i[IDX_BITS+4:5];
          start_d = req_start;
          cnt_d   = '0;
        end else if (write_i) begin
          state_d = WAIT;
          is_rd_d = 1'b0;
          idx_d   = address_i[IDX_BITS+4:5];
          start_d = 2'd0;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (last_wait) begin
          cnt_d   = '0;
          beat_d  = '0;
          state_d = is_rd_q ? RBURST : WBURST;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RBURST, WBURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_beat = beat_q + start_q;
  assign resp_o  = (state_q == RBURST) || (state_q == WBURST);
  assign burst_o = (state_q == RBURST) ? buf_q[BEAT_W*rd_beat +: BEAT_W] : '0;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed table-driven bench for burst_mem_responder (IDX_BITS=5, LATENCY=3).
module tb_burst_mem_responder;

  typedef struct {
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wd;
    logic        er;
    logic [63:0] eb;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] address_i = '0;
  logic [63:0] burst_i = '0;
  logic [63:0] burst_o;
  logic        resp_o;

  int errors = 0;
  int checks = 0;
  int vec_no = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  burst_mem_responder #(
    .IDX_BITS (5),
    .LATENCY  (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_o    (resp_o)
  );

  // Drive one cycle of inputs after the edge, check outputs mid-cycle.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset_n   = v.rst_n;
    read_i    = v.rd;
    write_i   = v.wr;
    address_i = v.addr;
    burst_i   = v.wd;
    @(negedge clk);
    checks++;
    if (resp_o !== v.er) begin
      errors++;
      $display("FAIL resp vec%0d: got %b expected %b", vec_no, resp_o, v.er);
    end
    checks++;
    if (burst_o !== v.eb) begin
      errors++;
      $display("FAIL burst vec%0d: got %h expected %h", vec_no, burst_o, v.eb);
    end
    vec_no++;
  endtask

  task automatic push(input logic rst_n, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [63:0] wd,
                      input logic er, input logic [63:0] eb);
    vec_t v;
    v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.addr = addr;
    v.wd = wd; v.er = er; v.eb = eb;
    tbl.push_back(v);
  endtask

  // Full write transaction: request, 3 wait cycles, 4 beats, DONE.
  task automatic push_write(input logic [31:0] addr, input logic [63:0] b0,
                            input logic [63:0] b1, input logic [63:0] b2,
                            input logic [63:0] b3);
    push(1, 0, 1, addr, 64'h0, 0, 64'h0);
    for (int i = 0; i < 3; i++) push(1, 0, 0, 32'h0, 64'h0, 0, 64'h0);
    push(1, 0, 0, 32'h0, b0, 1, 64'h0);
    push(1, 0, 0, 32'h0, b1, 1, 64'h0);
    push(1, 0, 0, 32'h0, b2, 1, 64'h0);
    push(1, 0, 0, 32'h0, b3, 1, 64'h0);
    push(1, 0, 0, 32'h0, 64'h0, 0, 64'h0);
  endtask

  // Full read transaction; wr selects a simultaneous (ignored) write request,
  // and garbage is driven on burst_i throughout.
  task automatic push_read(input logic [31:0] addr, input logic wr,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3);
    push(1, 1, wr, addr, 64'hDEAD_BEEF_0000_0000, 0, 64'h0);
    for (int i = 0; i < 3; i++) push(1, 0, 0, 32'h0, 64'hBAD0, 0, 64'h0);
    push(1, 0, 0, 32'h0, 64'hBAD1, 1, e0);
    push(1, 0, 0, 32'h0, 64'hBAD2, 1, e1);
    push(1, 0, 0, 32'h0, 64'hBAD3, 1, e2);
    push(1, 0, 0, 32'h0, 64'hBAD4, 1, e3);
    push(1, 0, 0, 32'h0, 64'h0, 0, 64'h0);
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

  initial begin
    vec_t v;
    // Reset held 3 cycles, then idle cycles with no request.
    for (int i = 0; i < 3; i++) push(0, 0, 0, 32'h0, 64'h0, 0, 64'h0);
    for (int i = 0; i < 3; i++) push(1, 0, 0, 32'h0, 64'h0, 0, 64'h0);
    // Basic write then read of 0x40.
    push_write(32'h40, B1, B2, B3, B4);
    push_read(32'h40, 0, B1, B2, B3, B4);
    // Alias: 0x400 maps to the same line as 0x000 with 5 index bits.
    push_write(32'h000, 64'hA000, 64'hA001, 64'hA002, 64'hA003);
    push_read(32'h400, 0, 64'hA000, 64'hA001, 64'hA002, 64'hA003);
    // Read and write together: the read wins, line B is untouched.
    push_write(32'h80, 64'hB000, 64'hB001, 64'hB002, 64'hB003);
    push_read(32'h80, 1, 64'hB000, 64'hB001, 64'hB002, 64'hB003);
    push_read(32'h80, 0, 64'hB000, 64'hB001, 64'hB002, 64'hB003);
    // Line D at 0xC0 for the interrupted-write case.
    push_write(32'hC0, 64'hD000, 64'hD001, 64'hD002, 64'hD003);

    foreach (tbl[i]) apply(tbl[i]);

    // Write of C over D with reset during the third beat.
    v = '{1, 0, 1, 32'hC0, 64'h0, 0, 64'h0};   apply(v);
    v = '{1, 0, 0, 32'h0, 64'h0, 0, 64'h0};    apply(v); apply(v); apply(v);
    v = '{1, 0, 0, 32'h0, 64'hC000, 1, 64'h0}; apply(v);
    v = '{1, 0, 0, 32'h0, 64'hC001, 1, 64'h0}; apply(v);
    v = '{0, 0, 0, 32'h0, 64'hC002, 1, 64'h0}; apply(v);
    v = '{1, 0, 0, 32'h0, 64'hC003, 0, 64'h0}; apply(v);
    v = '{1, 0, 0, 32'h0, 64'h0, 0, 64'h0};    apply(v);
    tbl.delete();
    push_read(32'hC0, 0, 64'hD000, 64'hD001, 64'hD002, 64'hD003);
    // Critical-word-first ordering for a read of 0x50 (word 2).
    push_write(32'h40, 64'hA0, 64'hA1, 64'hA2, 64'hA3);
`ifdef BURSTMEM_CRITICAL_WORD_FIRST_EN
    push_read(32'h50, 0, 64'hA2, 64'hA3, 64'hA0, 64'hA1);
`else
    push_read(32'h50, 0, 64'hA0, 64'hA1, 64'hA2, 64'hA3);
`endif
    foreach (tbl[i]) apply(tbl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
